iir_cascade_seq: RTL
====================

// Module: iir_cascade_seq
// PURPOSE
//  Time-multiplexed cascade of NSEC Direct-Form-I biquads on one shared MAC. Per start strobe: one
//  x sample through all sections, one (coef, data) product per cycle; final y presented with a done
//  pulse. Replaces fixed-coefficient selector + external sequencing: runtime-loadable coef bank, sections.
// PARAMETERS
//  W     `N   word width, data and coefficients (two's complement)
//  F     `F   fractional bits of Q format (coefficients and data)
//  NSEC  2    cascaded biquad sections, 1..4
// PORTS
//  clk          in   1                 system clock, all logic on rising edge
//  reset_n      in   1                 synchronous, active-low reset
//  coef_we      in   1                 coefficient write strobe
//  coef_addr    in   $clog2(5*NSEC)    5*sec+idx; idx 0:b0 1:b1 2:b2 3:a1 4:a2
//  coef_wdata   in   W                 coefficient value, Q(F)
//  clear_state  in   1                 abort run, zero all history/accumulator
//  start        in   1                 one-cycle sample strobe, x_in valid same cycle
//  x_in         in   W                 input sample
//  busy         out  1                 high from cycle after accepted start until done cycle
//  done         out  1                 one-cycle pulse, y_out valid from this cycle
//  y_out        out  W                 filtered sample, held until next done
//  overrun      out  1                 sticky: start seen while busy
//  sat_flag     out  1                 sticky: any section result clamped
// BEHAVIOUR
//  Reset: y_out=0, done=0, busy=0, overrun=0, sat_flag=0, histories x1,x2,y1,y2=0, acc=0,
//   coef bank: b0=1<<F per section, others 0 (identity filter).
//  Section k: y = b0*x + b1*x1 + b2*x2 + a1*y1 + a2*y2; a1,a2 stored pre-negated (all terms added).
//  Arithmetic: products 2W bits; acc 2W+3 bits signed; result = acc>>>F (truncate), then W-bit fit.
//  FSM: IDLE -> MAC (steps 0..4 = b0,b1,b2,a1,a2; step 0 loads acc=product) -> UPD -> MAC of next
//   section or DONE -> IDLE.
//  IDLE: start latches x_in into xcur, sec=0. UPD: x2<=x1, x1<=xcur, y2<=y1, y1<=y, xcur<=y, sec++.
//  DONE: y_out<=xcur, done=1 one cycle. Latency: done asserted 6*NSEC+1 cycles after start edge.
//  Back-to-back: start during DONE cycle ignored (sets overrun); accepted in IDLE only.
//  start while busy: ignored, overrun<=1, run unaffected.
//  coef_we honoured only in IDLE; ignored otherwise; coef_addr >= 5*NSEC ignored.
//  clear_state (any state): next cycle IDLE, busy=0, histories/acc/xcur zeroed, no done;
//   y_out, coefs, sticky flags kept. clear_state with start same cycle: clear wins.
//  Flags cleared only by reset_n.
// CONFIGURATION
//  IIR_SEQ_SAT_EN defined: section result clamped to [-2^(W-1), 2^(W-1)-1], sat_flag<=1 on clamp.
//  IIR_SEQ_SAT_EN undefined: result = low W bits (wrap), sat_flag tied 0.
// STRUCTURE
//  constantes.h: `N, `F, `IIR_NCOEF=5, coef index defines (B0..A2), state encodings
//   (IDLE, MAC, UPD, DONE).
//  Sub-module iir_mac_unit: multiply, accumulate/load, shift by F, saturate/wrap, clamp indication.
//  Top: coef register bank, per-section history registers, FSM + step/section counters.
// TESTING
//  Post-reset identity: start, x_in=0x000100 -> done at +6*NSEC+1, y_out=0x000100, busy high between.
//  Gain: sec0 b0=1<<(F-1), x_in=1000 -> y_out=500; other sections identity.
//  Recursion: NSEC sections identity except sec0 a1=+(1<<(F-1)); impulse x=1<<F then zeros ->
//   y_out = 1<<F, 1<<(F-1), 1<<(F-2).
//  Saturation (SAT_EN): sec0 b0=2^(W-1)-1, x_in=2^(W-1)-1 -> y_out=2^(W-1)-1, sat_flag=1;
//   non-SAT build: wrapped low W bits.
//  Protocol: start at start+2 -> overrun=1, same y_out/latency; coef_we during busy -> bank unchanged.
//  clear_state at step 3 of sec0 -> busy=0 next cycle, no done, next impulse behaves as from reset.

Source files
------------

// File: rtl/iir_cascade_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iir_cascade_seq_pkg
// Purpose  : Shared constants for the sequential biquad cascade: default
//            widths, coefficient slot indices and FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package iir_cascade_seq_pkg;

    localparam int c_W_DEFAULT = 24;
    localparam int c_F_DEFAULT = 16;
    localparam int c_NCOEF     = 5;

    localparam int c_IDX_B0 = 0;
    localparam int c_IDX_B1 = 1;
    localparam int c_IDX_B2 = 2;
    localparam int c_IDX_A1 = 3;
    localparam int c_IDX_A2 = 4;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_MAC  = 2'd1;
    localparam logic [1:0] c_S_UPD  = 2'd2;
    localparam logic [1:0] c_S_DONE = 2'd3;

    // True for the b0 slot of any section; those reset to unity gain.
    function automatic bit is_b0_slot(input int addr);
        return (addr % c_NCOEF) == c_IDX_B0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iir_cascade_seq_mac_unit.sv
`default_nettype none
// ============================================================================
// Module   : iir_cascade_seq_mac_unit
// Purpose  : Shared multiply-accumulate for the biquad cascade. Holds the
//            accumulator, scales by F and fits the result to W bits
//            (clamp when IIR_SEQ_SAT_EN is defined, wrap otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module iir_cascade_seq_mac_unit #(
    parameter int W = 24,
    parameter int F = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] coef,
    input  logic [W-1:0] data,
    output logic [W-1:0] result,
    output logic         clamp
);

    localparam int c_AW = 2 * W + 3;

    logic signed [2*W-1:0]  w_prod;
    logic signed [c_AW-1:0] w_prod_ext;
    logic signed [c_AW-1:0] w_shift;
    logic signed [c_AW-1:0] r_acc;

    assign w_prod     = $signed(coef) * $signed(data);
    assign w_prod_ext = {{3{w_prod[2*W-1]}}, w_prod};
    assign w_shift    = r_acc >>> F;

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= load ? w_prod_ext : (r_acc + w_prod_ext);
        end
    end

`ifdef IIR_SEQ_SAT_EN
    localparam logic signed [c_AW-1:0] c_MAX = {{(c_AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [c_AW-1:0] c_MIN = {{(c_AW-W+1){1'b1}}, {(W-1){1'b0}}};

    always_comb begin
        result = w_shift[W-1:0];
        clamp  = 1'b0;
        if (w_shift > c_MAX) begin
            result = c_MAX[W-1:0];
            clamp  = 1'b1;
        end else if (w_shift < c_MIN) begin
            result = c_MIN[W-1:0];
            clamp  = 1'b1;
        end
    end
`else
    logic w_unused_hi;

    assign result      = w_shift[W-1:0];
    assign clamp       = 1'b0;
    assign w_unused_hi = ^w_shift[c_AW-1:W];
`endif

endmodule
`default_nettype wire

// File: rtl/iir_cascade_seq.sv
`default_nettype none
// ============================================================================
// Module   : iir_cascade_seq
// Purpose  : NSEC Direct-Form-I biquads time-shared on one MAC, one product
//            per cycle, runtime-loadable coefficient bank. Result clamping is
//            enabled by defining IIR_SEQ_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module iir_cascade_seq
    import iir_cascade_seq_pkg::*;
#(
    parameter int W    = c_W_DEFAULT,
    parameter int F    = c_F_DEFAULT,
    parameter int NSEC = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            coef_we,
    input  logic [$clog2(c_NCOEF*NSEC)-1:0] coef_addr,
    input  logic [W-1:0]                    coef_wdata,
    input  logic                            clear_state,
    input  logic                            start,
    input  logic [W-1:0]                    x_in,
    output logic                            busy,
    output logic                            done,
    output logic [W-1:0]                    y_out,
    output logic                            overrun,
    output logic                            sat_flag
);

    localparam int c_NCOEF_TOT = c_NCOEF * NSEC;
    localparam int c_AW        = $clog2(c_NCOEF_TOT);
    localparam int c_SW        = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam logic [W-1:0] c_ONE = W'(1) << F;

    logic [1:0]      r_state, w_next;
    logic [2:0]      r_step;
    logic [c_SW-1:0] r_sec;

    logic [W-1:0] r_coef [c_NCOEF_TOT];
    logic [W-1:0] r_x1 [NSEC];
    logic [W-1:0] r_x2 [NSEC];
    logic [W-1:0] r_y1 [NSEC];
    logic [W-1:0] r_y2 [NSEC];
    logic [W-1:0] r_xcur;
    logic [W-1:0] r_y_out;
    logic         r_done, r_overrun, r_sat;

    logic            w_accept, w_mac_en, w_mac_load, w_upd, w_finish;
    logic            w_last_sec, w_coef_wr;
    logic [c_AW-1:0] w_cidx;
    logic [W-1:0]    w_coef, w_data, w_result;
    logic            w_clamp;

    assign w_last_sec = (r_sec == c_SW'(NSEC - 1));
    assign w_cidx     = c_AW'(int'(r_sec) * c_NCOEF + int'(r_step));
    assign w_coef     = r_coef[w_cidx];
    assign w_coef_wr  = (r_state == c_S_IDLE) && coef_we &&
                        (32'(coef_addr) < c_NCOEF_TOT);

    always_comb begin
        w_data = r_xcur;
        case (r_step)
            3'd1:    w_data = r_x1[r_sec];
            3'd2:    w_data = r_x2[r_sec];
            3'd3:    w_data = r_y1[r_sec];
            3'd4:    w_data = r_y2[r_sec];
            default: w_data = r_xcur;
        endcase
    end

    // Next-state and per-cycle controls; clear_state overrides everything.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_mac_en   = 1'b0;
        w_mac_load = 1'b0;
        w_upd      = 1'b0;
        w_finish   = 1'b0;
        if (clear_state) begin
            w_next = c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start && !r_done) begin
                        w_accept = 1'b1;
                        w_next   = c_S_MAC;
                    end
                end
                c_S_MAC: begin
                    w_mac_en   = 1'b1;
                    w_mac_load = (r_step == 3'd0);
                    if (r_step == 3'd4) begin
                        w_next = c_S_UPD;
                    end
                end
                c_S_UPD: begin
                    w_upd  = 1'b1;
                    w_next = w_last_sec ? c_S_DONE : c_S_MAC;
                end
                c_S_DONE: begin
                    w_finish = 1'b1;
                    w_next   = c_S_IDLE;
                end
                default: w_next = c_S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear_state || w_accept) begin
            r_step <= '0;
            r_sec  <= '0;
        end else if (w_mac_en) begin
            r_step <= (r_step == 3'd4) ? 3'd0 : (r_step + 3'd1);
        end else if (w_upd) begin
            r_sec <= r_sec + c_SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < c_NCOEF_TOT; i++) begin
                r_coef[i] <= is_b0_slot(i) ? c_ONE : '0;
            end
        end else if (w_coef_wr) begin
            r_coef[coef_addr] <= coef_wdata;
        end
    end

    // The section result becomes both its own y1 and the next section's input.
    always_ff @(posedge clk) begin
        if (!reset_n || clear_state) begin
            for (int s = 0; s < NSEC; s++) begin
                r_x1[s] <= '0;
                r_x2[s] <= '0;
                r_y1[s] <= '0;
                r_y2[s] <= '0;
            end
            r_xcur <= '0;
        end else begin
            if (w_accept) begin
                r_xcur <= x_in;
            end
            if (w_upd) begin
                for (int s = 0; s < NSEC; s++) begin
                    if (r_sec == c_SW'(s)) begin
                        r_x2[s] <= r_x1[s];
                        r_x1[s] <= r_xcur;
                        r_y2[s] <= r_y1[s];
                        r_y1[s] <= w_result;
                    end
                end
                r_xcur <= w_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_y_out   <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_y_out <= r_xcur;
            end
            if (start && !clear_state && ((r_state != c_S_IDLE) || r_done)) begin
                r_overrun <= 1'b1;
            end
            if (w_upd && w_clamp) begin
                r_sat <= 1'b1;
            end
        end
    end

    iir_cascade_seq_mac_unit #(
        .W (W),
        .F (F)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear_state),
        .en      (w_mac_en),
        .load    (w_mac_load),
        .coef    (w_coef),
        .data    (w_data),
        .result  (w_result),
        .clamp   (w_clamp)
    );

    assign busy     = (r_state != c_S_IDLE);
    assign done     = r_done;
    assign y_out    = r_y_out;
    assign overrun  = r_overrun;
    assign sat_flag = r_sat;

endmodule
`default_nettype wire
